video_frame_buf_sched: RTL and testbench

- Frame-buffer scheduler sitting between the processor-facing registers, the video_in_store write engine and the video output reader.
- Rotates NB_BUF frame buffers in RAM using a latest-frame triple-buffering policy.
- Hands video_in_store a fresh base address plus new-address strobe after each completed frame, and hands the reader the newest complete frame at each reader frame start.
- Stretches the store completion into a processor interrupt of at least IRQ_CYCLES cycles.

---
 rtl/video_frame_pkg.sv | 39 +++
 rtl/video_irq_stretch.sv | 28 ++
 rtl/video_frame_buf_sched.sv | 175 +++++++++++++++++
 tb/tb_video_frame_buf_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_pkg.sv
// Shared types and the buffer address helper for the frame-buffer scheduler.
package video_frame_pkg;

    // Lifecycle of one frame buffer in RAM.
    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_WRITING = 2'd1,
        BUF_READY   = 2'd2,
        BUF_READING = 2'd3
    } buf_state_t;

    // Producer FSM driving video_in_store.
    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_ISSUE   = 2'd1,
        P_WRITING = 2'd2
    } prod_state_t;

    // Up to four buffers are supported.
    typedef logic [1:0] buf_idx_t;

    localparam int MAX_BUF = 4;

    // Base address of buffer idx built from shifts and adds only; always
    // called with constant base/stride so it folds into a constant table.
    function automatic logic [31:0] buf_addr(input buf_idx_t idx,
                                             input logic [31:0] base,
                                             input logic [31:0] stride);
        logic [31:0] a;
        case (idx)
            2'd0:    a = base;
            2'd1:    a = base + stride;
            2'd2:    a = base + (stride << 1);
            default: a = base + (stride << 1) + stride;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/video_irq_stretch.sv
// Stretches a single-cycle pulse into a level held for IRQ_CYCLES cycles;
// a new pulse while the level is high restarts the count.
module video_irq_stretch #(
    parameter int unsigned IRQ_CYCLES = 3
) (
    input  logic clk,
    input  logic nRST,
    input  logic pulse,
    output logic irq
);
    localparam int CW = $clog2(IRQ_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Load on pulse, otherwise count down to zero.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (pulse) begin
            cnt <= CW'(IRQ_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign irq = (cnt != '0);

endmodule

// File: rtl/video_frame_buf_sched.sv
// Latest-frame triple-buffer scheduler between video_in_store (producer)
// and the video output reader (consumer).
//
// Interface handshake: store_ctr[0] is a one-cycle new-address strobe; the
// matching store_addr is loaded one cycle before the strobe and held until
// the next strobe. store_done is a one-cycle completion pulse accepted only
// while the producer is in P_WRITING. rd_frame_req is a one-cycle vsync
// pulse; rd_addr/rd_valid update on the following cycle.
module video_frame_buf_sched
    import video_frame_pkg::*;
#(
    parameter int unsigned NB_BUF      = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned FRAME_BYTES = 307200,
    parameter int unsigned IRQ_CYCLES  = 3
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        enable,
    output logic [31:0] store_ctr,
    output logic [31:0] store_addr,
    input  logic        store_done,
    input  logic        rd_frame_req,
    output logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic        irq,
    output logic [15:0] dropped_cnt,
    output logic        err,
    output prod_state_t dbg_state
);
    localparam logic [31:0] STRIDE = 32'(FRAME_BYTES);

    localparam logic [31:0] ADDR_TAB [0:MAX_BUF-1] = '{
        buf_addr(2'd0, BASE_ADDR, STRIDE),
        buf_addr(2'd1, BASE_ADDR, STRIDE),
        buf_addr(2'd2, BASE_ADDR, STRIDE),
        buf_addr(2'd3, BASE_ADDR, STRIDE)
    };

    prod_state_t state, nstate;
    buf_state_t  bstate [NB_BUF];
    buf_state_t  nb     [NB_BUF];
    logic        strobe_q;
    logic [31:0] n_store_addr, n_rd_addr;
    logic        n_rd_valid, n_err;
    logic [15:0] n_drop;
    logic        done_acc, need_pick;
    logic        rdy_found, free_found;
    buf_idx_t    rdy_idx, free_idx;

    // Next-state for producer, buffer table and reader; done is resolved
    // before the reader, and the free-buffer pick comes last so it sees
    // buffers released by either.
    always_comb begin
        nstate       = state;
        nb           = bstate;
        n_store_addr = store_addr;
        n_rd_addr    = rd_addr;
        n_rd_valid   = rd_valid;
        n_drop       = dropped_cnt;
        n_err        = err;
        done_acc     = 1'b0;
        need_pick    = 1'b0;
        rdy_found    = 1'b0;
        rdy_idx      = '0;
        free_found   = 1'b0;
        free_idx     = '0;

        case (state)
            P_IDLE:    need_pick = enable;
            P_ISSUE:   nstate = P_WRITING;
            P_WRITING: done_acc = store_done;
            default:   nstate = P_IDLE;
        endcase

        if (store_done && (state != P_WRITING)) begin
            n_err = 1'b1;
        end

        if (done_acc) begin
            for (int i = 0; i < NB_BUF; i++) begin
                if (nb[i] == BUF_READY) begin
                    nb[i] = BUF_FREE;
                    if (n_drop != 16'hFFFF) begin
                        n_drop = n_drop + 16'd1;
                    end
                end
            end
            for (int i = 0; i < NB_BUF; i++) begin
                if (nb[i] == BUF_WRITING) begin
                    nb[i] = BUF_READY;
                end
            end
            if (enable) begin
                need_pick = 1'b1;
            end else begin
                nstate = P_IDLE;
            end
        end

        if (rd_frame_req) begin
            for (int i = 0; i < NB_BUF; i++) begin
                if (nb[i] == BUF_READY) begin
                    rdy_found = 1'b1;
                    rdy_idx   = buf_idx_t'(i);
                end
            end
            if (rdy_found) begin
                for (int i = 0; i < NB_BUF; i++) begin
                    if (nb[i] == BUF_READING) begin
                        nb[i] = BUF_FREE;
                    end
                end
                nb[rdy_idx] = BUF_READING;
                n_rd_addr   = ADDR_TAB[rdy_idx];
                n_rd_valid  = 1'b1;
            end
        end

        if (need_pick) begin
            for (int i = NB_BUF - 1; i >= 0; i--) begin
                if (nb[i] == BUF_FREE) begin
                    free_found = 1'b1;
                    free_idx   = buf_idx_t'(i);
                end
            end
            if (free_found) begin
                nb[free_idx] = BUF_WRITING;
                n_store_addr = ADDR_TAB[free_idx];
                nstate       = P_ISSUE;
            end else begin
                nstate = P_IDLE;
            end
        end
    end

    // State and output registers; the strobe is registered from P_ISSUE so
    // store_addr is already stable when bit0 rises.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= P_IDLE;
            for (int i = 0; i < NB_BUF; i++) begin
                bstate[i] <= BUF_FREE;
            end
            strobe_q    <= 1'b0;
            store_addr  <= BASE_ADDR;
            rd_addr     <= BASE_ADDR;
            rd_valid    <= 1'b0;
            dropped_cnt <= '0;
            err         <= 1'b0;
        end else begin
            state       <= nstate;
            bstate      <= nb;
            strobe_q    <= (state == P_ISSUE);
            store_addr  <= n_store_addr;
            rd_addr     <= n_rd_addr;
            rd_valid    <= n_rd_valid;
            dropped_cnt <= n_drop;
            err         <= n_err;
        end
    end

    assign store_ctr = {31'b0, strobe_q};
    assign dbg_state = state;

    video_irq_stretch #(
        .IRQ_CYCLES(IRQ_CYCLES)
    ) u_irq (
        .clk   (clk),
        .nRST  (nRST),
        .pulse (done_acc),
        .irq   (irq)
    );

endmodule

// File: tb/tb_video_frame_buf_sched.sv
// Directed bench for video_frame_buf_sched with hand-computed expectations.
module tb_video_frame_buf_sched;
    import video_frame_pkg::*;

    localparam logic [31:0] A0 = 32'h4000_0000;
    localparam logic [31:0] A1 = 32'h4004_B000;
    localparam logic [31:0] A2 = 32'h4009_6000;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] store_ctr;
    logic [31:0] store_addr;
    logic        store_done = 1'b0;
    logic        rd_frame_req = 1'b0;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic        irq;
    logic [15:0] dropped_cnt;
    logic        err;
    prod_state_t dbg_state;

    int checks = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    video_frame_buf_sched dut (
        .clk          (clk),
        .nRST         (nRST),
        .enable       (enable),
        .store_ctr    (store_ctr),
        .store_addr   (store_addr),
        .store_done   (store_done),
        .rd_frame_req (rd_frame_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .irq          (irq),
        .dropped_cnt  (dropped_cnt),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #12;
        checks++;
        if (store_ctr !== 32'h0 || store_addr !== A0 || rd_addr !== A0 ||
            rd_valid !== 1'b0 || irq !== 1'b0 || dropped_cnt !== 16'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: ctr=%h saddr=%h raddr=%h rv=%b irq=%b drop=%0d err=%b",
                     store_ctr, store_addr, rd_addr, rd_valid, irq, dropped_cnt, err);
        end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_first_strobe();
        enable = 1'b1;
        tick();
        checks++;
        if (store_ctr !== 32'h0 || store_addr !== A0) begin
            failures++;
            $display("FAIL first_addr: ctr=%h addr=%h want ctr=0 addr=%h", store_ctr, store_addr, A0);
        end
        tick();
        checks++;
        if (store_ctr !== 32'h1) begin
            failures++;
            $display("FAIL first_strobe: ctr=%h want 1", store_ctr);
        end
        tick();
        checks++;
        if (store_ctr !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL strobe_one_cycle: ctr=%h irq=%b want 0 0", store_ctr, irq);
        end
    endtask

    task automatic test_done_irq();
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        checks++;
        if (irq !== 1'b1 || store_addr !== A1 || store_ctr !== 32'h0) begin
            failures++;
            $display("FAIL done_c1: irq=%b addr=%h ctr=%h want 1 %h 0", irq, store_addr, store_ctr, A1);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || store_ctr !== 32'h1) begin
            failures++;
            $display("FAIL done_c2: irq=%b ctr=%h want 1 1", irq, store_ctr);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || store_ctr !== 32'h0) begin
            failures++;
            $display("FAIL done_c3: irq=%b ctr=%h want 1 0", irq, store_ctr);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_len: irq=%b want 0", irq);
        end
    endtask

    task automatic test_reader();
        rd_frame_req = 1'b1;
        tick();
        rd_frame_req = 1'b0;
        checks++;
        if (rd_addr !== A0 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL read_first: addr=%h valid=%b want %h 1", rd_addr, rd_valid, A0);
        end
        rd_frame_req = 1'b1;
        tick();
        rd_frame_req = 1'b0;
        checks++;
        if (rd_addr !== A0 || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL read_repeat: addr=%h valid=%b want %h 1", rd_addr, rd_valid, A0);
        end
    endtask

    // three completions with no reads: buf0 stays READING, 1 and 2 alternate
    task automatic test_drop();
        logic [31:0] exp_addr [3];
        logic [15:0] exp_drop [3];
        exp_addr[0] = A2; exp_addr[1] = A1; exp_addr[2] = A2;
        exp_drop[0] = 16'd0; exp_drop[1] = 16'd1; exp_drop[2] = 16'd2;
        for (int k = 0; k < 3; k++) begin
            store_done = 1'b1;
            tick();
            store_done = 1'b0;
            checks++;
            if (store_addr !== exp_addr[k] || dropped_cnt !== exp_drop[k]) begin
                failures++;
                $display("FAIL drop_step%0d: addr=%h drop=%0d want %h %0d",
                         k, store_addr, dropped_cnt, exp_addr[k], exp_drop[k]);
            end
            tick();
            tick();
        end
        checks++;
        if (rd_addr !== A0) begin
            failures++;
            $display("FAIL drop_reader_kept: addr=%h want %h", rd_addr, A0);
        end
    endtask

    // consume READY buf1, then done and read land in the same cycle
    task automatic test_back_to_back();
        rd_frame_req = 1'b1;
        tick();
        rd_frame_req = 1'b0;
        checks++;
        if (rd_addr !== A1) begin
            failures++;
            $display("FAIL read_buf1: addr=%h want %h", rd_addr, A1);
        end
        store_done = 1'b1;
        rd_frame_req = 1'b1;
        tick();
        store_done = 1'b0;
        rd_frame_req = 1'b0;
        checks++;
        if (rd_addr !== A2 || dropped_cnt !== 16'd2 || store_addr !== A0) begin
            failures++;
            $display("FAIL simul: raddr=%h drop=%0d saddr=%h want %h 2 %h",
                     rd_addr, dropped_cnt, store_addr, A2, A0);
        end
        tick();
        tick();
    endtask

    task automatic test_enable_low_err();
        enable = 1'b0;
        tick();
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        checks++;
        if (dbg_state !== P_IDLE || irq !== 1'b1 || err !== 1'b0 || dropped_cnt !== 16'd2) begin
            failures++;
            $display("FAIL enable_low_done: st=%0d irq=%b err=%b drop=%0d want 0 1 0 2",
                     dbg_state, irq, err, dropped_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (store_ctr !== 32'h0) begin
                failures++;
                $display("FAIL no_strobe_when_disabled: ctr=%h want 0", store_ctr);
            end
        end
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        checks++;
        if (err !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL err_idle_done: err=%b irq=%b want 1 0", err, irq);
        end
    endtask

    // buffers now: 0 READY, 1 FREE, 2 READING
    task automatic test_reset_mid();
        enable = 1'b1;
        tick();
        checks++;
        if (store_addr !== A1) begin
            failures++;
            $display("FAIL restart_pick: addr=%h want %h", store_addr, A1);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (store_ctr !== 32'h0 || store_addr !== A0 || rd_addr !== A0 ||
            rd_valid !== 1'b0 || irq !== 1'b0 || dropped_cnt !== 16'h0 || err !== 1'b0 ||
            dbg_state !== P_IDLE) begin
            failures++;
            $display("FAIL async_reset: ctr=%h saddr=%h raddr=%h rv=%b irq=%b drop=%0d err=%b st=%0d",
                     store_ctr, store_addr, rd_addr, rd_valid, irq, dropped_cnt, err, dbg_state);
        end
        nRST = 1'b1;
        tick();
        checks++;
        if (store_addr !== A0 || store_ctr !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_addr: addr=%h ctr=%h want %h 0", store_addr, store_ctr, A0);
        end
        tick();
        checks++;
        if (store_ctr !== 32'h1) begin
            failures++;
            $display("FAIL post_reset_strobe: ctr=%h want 1", store_ctr);
        end
    endtask

    initial begin
        test_reset();
        test_first_strobe();
        test_done_irq();
        test_reader();
        test_drop();
        test_back_to_back();
        test_enable_low_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
